// File: rtl/comb_event_buffer.sv
// Ping-pong event buffer; optional out_wcount port under COMB_EVENT_BUFFER_WCOUNT_EN.
// Latency: first word is presented one cycle after done_read. Full throughput on the drain.
// Backpressure: in_ready drops while the write bank is full; output holds while out_ready is low.
module comb_event_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_eoe,
    output logic              in_ready,
    input  logic              input_enable_1,
    input  logic              input_enable_2,
    input  logic              output_enable_1,
    input  logic              output_enable_2,
    output logic              done_read,
    output logic              done_write,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
`ifdef COMB_EVENT_BUFFER_WCOUNT_EN
    output logic [ADDR_W:0]   out_wcount,
`endif
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH;
    localparam logic [ADDR_W:0] LEN_ONE = 1;

    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [1:0]        full;
    logic [ADDR_W:0]   len [2];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              w_bank;
    logic              r_sel;
    logic              rd_bank;
    logic              wr_acc;
    logic              wr_mem;
    logic              unused_enables;

    // Bank 1 wins when both enables are high; the *_2 selects are implied.
    assign w_bank         = !input_enable_1;
    assign r_sel          = !output_enable_1;
    assign unused_enables = input_enable_2 ^ output_enable_2;

    assign in_ready = !full[w_bank];
    assign wr_acc   = in_valid && in_ready;
    assign wr_mem   = wr_acc && (wptr != DEPTH_L);

`ifdef COMB_EVENT_BUFFER_WCOUNT_EN
    assign out_wcount = out_valid ? len[rd_bank] : '0;
`endif

    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (wr_mem) begin
            mem[{w_bank, wptr[ADDR_W-1:0]}] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full       <= '0;
            len[0]     <= '0;
            len[1]     <= '0;
            wptr       <= '0;
            rptr       <= '0;
            rd_bank    <= 1'b0;
            done_read  <= 1'b0;
            done_write <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            done_read  <= 1'b0;
            done_write <= 1'b0;

            if (wr_acc) begin
                if (wptr == DEPTH_L) begin
                    overflow <= 1'b1;
                end else begin
                    wptr <= wptr + 1'b1;
                end
                if (in_eoe) begin
                    full[w_bank] <= 1'b1;
                    len[w_bank]  <= (wptr == DEPTH_L) ? DEPTH_L : wptr + 1'b1;
                    wptr         <= '0;
                    done_read    <= 1'b1;
                end
            end

            // A bank being read is always full, so the write above never
            // targets the bank whose flag is cleared here.
            if (!out_valid) begin
                if (full[r_sel]) begin
                    rd_bank   <= r_sel;
                    out_data  <= mem[{r_sel, {ADDR_W{1'b0}}}];
                    out_last  <= (len[r_sel] == LEN_ONE);
                    out_valid <= 1'b1;
                    rptr      <= LEN_ONE;
                end
            end else if (out_ready) begin
                if (out_last) begin
                    full[rd_bank] <= 1'b0;
                    rptr          <= '0;
                    out_valid     <= 1'b0;
                    out_last      <= 1'b0;
                    done_write    <= 1'b1;
                end else begin
                    out_data <= mem[{rd_bank, rptr[ADDR_W-1:0]}];
                    out_last <= (rptr == len[rd_bank] - 1'b1);
                    rptr     <= rptr + 1'b1;
                end
            end
        end
    end

endmodule
